// File: rtl/subleq_loader_if.sv
// -----------------------------------------------------------------------------
// subleq_loader_if
// Groups the boot-loader byte stream handshake and the memory write port.
//   in_valid  : stream source has a byte on in_byte
//   in_ready  : loader accepts a byte this cycle
//   in_byte   : stream byte
//   mem_we    : one-cycle memory write strobe
//   mem_addr  : write address
//   mem_wdata : write data
// modport master : stream source / memory sink side (testbench, upstream logic)
// modport slave  : the loader itself
// -----------------------------------------------------------------------------
interface subleq_loader_if #(
    parameter int WORD_SIZE = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [7:0]           in_byte;
    logic                 mem_we;
    logic [WORD_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;

    modport master (
        output in_valid,
        output in_byte,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_byte,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/subleq_loader.sv
// -----------------------------------------------------------------------------
// subleq_loader
// Boot-time program loader. Receives a byte stream made of a length header
// followed by little-endian words, assembles WORD_SIZE-bit words and writes
// them to memory addresses 0,1,2,... The CPU is held in reset until the whole
// image is written; an oversize header aborts the load and latches error.
//
// Ports
//   clk          : system clock, rising edge
//   areset       : synchronous active-low reset
//   bus          : subleq_loader_if.slave (byte stream in, memory write out)
//   cpu_run      : 1 once the image is loaded (CPU released)
//   error        : 1 when the header count exceeds MEM_DEPTH
//   words_loaded : number of words written so far
// -----------------------------------------------------------------------------

// Protocol invariants of the loader outputs, kept apart from the datapath.
module subleq_loader_chk (
    input logic clk,
    input logic areset,
    input logic cpu_run,
    input logic error,
    input logic mem_we,
    input logic in_ready
);
    // Done and error are mutually exclusive terminal states.
    a_run_err_excl: assert property (@(posedge clk) disable iff (!areset)
        !(cpu_run && error));

    // No byte can be taken while a word is being written.
    a_no_ready_in_write: assert property (@(posedge clk) disable iff (!areset)
        mem_we |-> !in_ready);

    // The write strobe never lasts more than one cycle.
    a_we_single_cycle: assert property (@(posedge clk) disable iff (!areset)
        mem_we |=> !mem_we);
endmodule

module subleq_loader #(
    parameter int WORD_SIZE = 16,
    parameter int MEM_DEPTH = 65536
) (
    input  logic                 clk,
    input  logic                 areset,
    subleq_loader_if.slave       bus,
    output logic                 cpu_run,
    output logic                 error,
    output logic [WORD_SIZE-1:0] words_loaded
);
    localparam int B   = WORD_SIZE / 8;
    localparam int BCW = (B > 1) ? $clog2(B) : 1;
    // Counts are one bit wider than a word so a full-memory image is legal.
    localparam int CW  = WORD_SIZE + 1;

    localparam logic [BCW-1:0] LAST_BYTE_C = BCW'(B - 1);
    localparam logic [CW-1:0]  MEM_DEPTH_C = CW'(MEM_DEPTH);

    typedef enum logic [2:0] {
        ST_HDR   = 3'd0,
        ST_DATA  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    state_t               state_q,     state_d;
    logic [BCW-1:0]       byte_cnt_q,  byte_cnt_d;
    logic [WORD_SIZE-1:0] word_q,      word_d;
    logic [CW-1:0]        n_q,         n_d;
    logic [CW-1:0]        words_q,     words_d;
    logic [WORD_SIZE-1:0] mem_addr_q,  mem_addr_d;
    logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
    logic                 in_ready_q,  in_ready_d;
    logic                 mem_we_q,    mem_we_d;
    logic                 cpu_run_q,   cpu_run_d;
    logic                 error_q,     error_d;

    logic                 accept_s;
    logic                 last_byte_s;
    logic [BCW-1:0]       next_cnt_s;
    logic [WORD_SIZE-1:0] asm_s;
    logic [CW-1:0]        words_inc_s;

    // Byte handshake and assembly of the current byte into the word in progress.
    always_comb begin
        accept_s    = bus.in_valid && in_ready_q;
        last_byte_s = (byte_cnt_q == LAST_BYTE_C);
        if (last_byte_s) begin
            next_cnt_s = {BCW{1'b0}};
        end else begin
            next_cnt_s = byte_cnt_q + BCW'(1);
        end
        // Bytes arrive LSB first: byte k of a word lands in bits [8k+7:8k].
        asm_s = word_q;
        for (int i = 0; i < B; i++) begin
            if (byte_cnt_q == BCW'(i)) begin
                asm_s[8*i +: 8] = bus.in_byte;
            end else begin
                asm_s[8*i +: 8] = word_q[8*i +: 8];
            end
        end
        words_inc_s = words_q + CW'(1);
    end

    // Next-state and datapath update of the load FSM, plus registered outputs.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        n_d         = n_q;
        words_d     = words_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            ST_HDR: begin
                if (accept_s) begin
                    byte_cnt_d = next_cnt_s;
                    if (last_byte_s) begin
                        word_d = {WORD_SIZE{1'b0}};
                        n_d    = {1'b0, asm_s};
                        if (asm_s == {WORD_SIZE{1'b0}}) begin
                            state_d = ST_DONE;
                        end else if ({1'b0, asm_s} > MEM_DEPTH_C) begin
                            state_d = ST_ERR;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        word_d = asm_s;
                    end
                end else begin
                    // in_valid low: partial header and byte count are held.
                    state_d = ST_HDR;
                end
            end
            ST_DATA: begin
                if (accept_s) begin
                    byte_cnt_d = next_cnt_s;
                    if (last_byte_s) begin
                        word_d      = {WORD_SIZE{1'b0}};
                        mem_wdata_d = asm_s;
                        mem_addr_d  = words_q[WORD_SIZE-1:0];
                        state_d     = ST_WRITE;
                    end else begin
                        word_d = asm_s;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_WRITE: begin
                words_d = words_inc_s;
                if (words_inc_s == n_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                // Unreachable encoding: restart the load from the header.
                state_d    = ST_HDR;
                byte_cnt_d = {BCW{1'b0}};
                word_d     = {WORD_SIZE{1'b0}};
                words_d    = {CW{1'b0}};
            end
        endcase

        // Outputs are registered from the next state so they align with state_q.
        in_ready_d = (state_d == ST_HDR) || (state_d == ST_DATA);
        mem_we_d   = (state_d == ST_WRITE);
        cpu_run_d  = (state_d == ST_DONE);
        error_d    = (state_d == ST_ERR);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!areset) begin
            state_q     <= ST_HDR;
            byte_cnt_q  <= {BCW{1'b0}};
            word_q      <= {WORD_SIZE{1'b0}};
            n_q         <= {CW{1'b0}};
            words_q     <= {CW{1'b0}};
            mem_addr_q  <= {WORD_SIZE{1'b0}};
            mem_wdata_q <= {WORD_SIZE{1'b0}};
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            cpu_run_q   <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            n_q         <= n_d;
            words_q     <= words_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            cpu_run_q   <= cpu_run_d;
            error_q     <= error_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign cpu_run       = cpu_run_q;
    assign error         = error_q;
    // words_q never exceeds MEM_DEPTH; the top bit only matters for the count compare.
    assign words_loaded  = words_q[WORD_SIZE-1:0];

    subleq_loader_chk u_chk (
        .clk      (clk),
        .areset   (areset),
        .cpu_run  (cpu_run_q),
        .error    (error_q),
        .mem_we   (mem_we_q),
        .in_ready (in_ready_q)
    );
endmodule

// File: tb/tb_subleq_loader.sv
// -----------------------------------------------------------------------------
// tb_subleq_loader
// Self-checking bench for subleq_loader (WORD_SIZE=16, MEM_DEPTH=16).
// Table of short streams with expected final status, plus hand-written
// sequences for latency, full-memory load with gaps, mid-load reset and
// post-DONE input. Memory writes are checked against a queue of expected
// {addr,data} pushed as the stream is driven.
// -----------------------------------------------------------------------------
module tb_subleq_loader;
    localparam int W     = 16;
    localparam int DEPTH = 16;

    logic         clk;
    logic         areset;
    logic         cpu_run;
    logic         error;
    logic [W-1:0] words_loaded;

    subleq_loader_if #(.WORD_SIZE(W)) bus ();

    subleq_loader #(.WORD_SIZE(W), .MEM_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .areset       (areset),
        .bus          (bus),
        .cpu_run      (cpu_run),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [W-1:0] addr;
        logic [W-1:0] data;
    } wr_t;

    typedef struct packed {
        logic [3:0]  n;      // bytes in the stream
        logic [79:0] data;   // byte i at bits [8i+7:8i]
        logic        run;
        logic        err;
        logic [15:0] words;
    } vec_t;

    wr_t          exp_q[$];
    logic [W-1:0] mem_model [DEPTH];
    vec_t         vecs [8];

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_tests++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act_v, exp_v, $time);
        end
    endtask

    // Memory-side monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        wr_t e;
        check("run_err_excl", 32'(cpu_run & error), 32'd0);
        if (areset && bus.mem_we) begin
            check("ready_in_write", 32'(bus.in_ready), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(bus.mem_addr), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
                check("wr_data", 32'(bus.mem_wdata), 32'(e.data));
                if (bus.mem_addr < DEPTH) mem_model[bus.mem_addr[3:0]] <= bus.mem_wdata;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        areset       = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;
        @(negedge clk);
        check("rst_outputs",
              32'({bus.in_ready, bus.mem_we, cpu_run, error,
                   |bus.mem_addr, |bus.mem_wdata, |words_loaded}), 32'd0);
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) mem_model[i] = 16'h0000;
        areset = 1'b1;
    endtask

    // Present a byte (after optional idle cycles) and wait, bounded, for acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int k;
        k = 0;
        repeat (gap) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        while (!bus.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) check("handshake_timeout", 32'(k), 32'd0);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Drive a byte for one cycle into a terminal loader; it must not be ready.
    task automatic blind_byte(input logic [7:0] b);
        @(negedge clk);
        check("ready_terminal", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Replay one table entry; a tiny stream model decides when the loader goes terminal.
    task automatic apply_vec(input vec_t v);
        logic [W-1:0] hdr;
        int           words;
        bit           term;
        do_reset();
        hdr   = v.data[15:0];
        words = 0;
        term  = 1'b0;
        for (int i = 0; i < int'(v.n); i++) begin
            if (term) begin
                blind_byte(v.data[8*i +: 8]);
            end else begin
                if (i >= 2 && (i % 2) == 1) push_exp(W'((i - 2) / 2), v.data[8*(i-1) +: 16]);
                send_byte(v.data[8*i +: 8], 0);
                if (i == 1 && (hdr == 16'd0 || int'(hdr) > DEPTH)) term = 1'b1;
                if (i >= 2 && (i % 2) == 1) begin
                    words++;
                    if (words == int'(hdr)) term = 1'b1;
                end
            end
        end
        repeat (3) @(negedge clk);
        check("vec_cpu_run", 32'(cpu_run), 32'(v.run));
        check("vec_error", 32'(error), 32'(v.err));
        check("vec_words_loaded", 32'(words_loaded), 32'(v.words));
        check("vec_writes_pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] d;
        areset       = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;

        vecs[0] = '{n: 4'd6,  data: 80'h0000_0000_5678_1234_0002, run: 1'b1, err: 1'b0, words: 16'd2};
        vecs[1] = '{n: 4'd2,  data: 80'h0000_0000_0000_0000_0000, run: 1'b1, err: 1'b0, words: 16'd0};
        vecs[2] = '{n: 4'd6,  data: 80'h0000_0000_BBBB_AAAA_0011, run: 1'b0, err: 1'b1, words: 16'd0};
        vecs[3] = '{n: 4'd4,  data: 80'h0000_0000_0000_BEEF_0001, run: 1'b1, err: 1'b0, words: 16'd1};
        vecs[4] = '{n: 4'd8,  data: 80'h0000_FFFF_0002_0001_0003, run: 1'b1, err: 1'b0, words: 16'd3};
        vecs[5] = '{n: 4'd4,  data: 80'h0000_0000_0000_0000_FFFF, run: 1'b0, err: 1'b1, words: 16'd0};
        vecs[6] = '{n: 4'd6,  data: 80'h0000_0000_7777_6655_0000, run: 1'b1, err: 1'b0, words: 16'd0};
        vecs[7] = '{n: 4'd10, data: 80'hDDDD_CCCC_BBBB_AAAA_0004, run: 1'b1, err: 1'b0, words: 16'd4};

        for (int t = 0; t < 8; t++) apply_vec(vecs[t]);

        // Write latency and cpu_run timing on the two-word image.
        do_reset();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h34, 0);
        push_exp(16'd0, 16'h1234);
        send_byte(8'h12, 0);
        send_byte(8'h78, 0);
        push_exp(16'd1, 16'h5678);
        send_byte(8'h56, 0);
        @(negedge clk);
        check("lat_mem_we", 32'(bus.mem_we), 32'd1);
        check("lat_in_ready", 32'(bus.in_ready), 32'd0);
        check("lat_run_early", 32'(cpu_run), 32'd0);
        @(negedge clk);
        check("lat_we_drop", 32'(bus.mem_we), 32'd0);
        check("lat_run_rise", 32'(cpu_run), 32'd1);

        // Empty image: cpu_run right after the header, no write.
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        check("empty_run", 32'(cpu_run), 32'd1);
        check("empty_err", 32'(error), 32'd0);

        // Full memory (N == MEM_DEPTH) with random in_valid gaps.
        do_reset();
        send_byte(8'h10, $urandom_range(0, 3));
        send_byte(8'h00, $urandom_range(0, 3));
        for (int k = 0; k < DEPTH; k++) begin
            d = W'(16'h1357 * (k + 1));
            push_exp(W'(k), d);
            send_byte(d[7:0], $urandom_range(0, 3));
            send_byte(d[15:8], $urandom_range(0, 3));
        end
        repeat (3) @(negedge clk);
        check("full_words", 32'(words_loaded), 32'd16);
        check("full_run", 32'(cpu_run), 32'd1);
        check("full_err", 32'(error), 32'd0);
        check("full_pending", 32'(exp_q.size()), 32'd0);
        check("full_last_mem", 32'(mem_model[15]), 32'(16'(16'h1357 * 16)));

        // Input after DONE is ignored.
        for (int k = 0; k < 10; k++) blind_byte(8'(k + 8'hA0));
        check("done_words_held", 32'(words_loaded), 32'd16);
        check("done_run_held", 32'(cpu_run), 32'd1);

        // Reset in the middle of a word discards the partial data.
        do_reset();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h34, 0);
        @(negedge clk);
        areset       = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("midrst_words", 32'(words_loaded), 32'd0);
        check("midrst_ready", 32'(bus.in_ready), 32'd0);
        areset = 1'b1;
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        push_exp(16'd0, 16'h1234);
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        push_exp(16'd1, 16'h5678);
        send_byte(8'h78, 0);
        send_byte(8'h56, 0);
        repeat (3) @(negedge clk);
        check("midrst_mem0", 32'(mem_model[0]), 32'h1234);
        check("midrst_mem1", 32'(mem_model[1]), 32'h5678);
        check("midrst_run", 32'(cpu_run), 32'd1);
        check("midrst_pending", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
